// File: rtl/ob_pkg.sv
// Shared constants for the output-buffer arbiter: FSM state encoding and the ack timeout.
package ob_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_WRITE = 2'd1;
  localparam state_t ST_WAIT  = 2'd2;

  // WAIT cycles allowed for ob_stored before the write is abandoned
  localparam int TIMEOUT = 4;
  localparam int TMR_W   = $clog2(TIMEOUT);

endpackage

// File: rtl/ob_arbiter_if.sv
// Requester/buffer-side signal bundle of ob_arbiter; master is the arbiter, slave the environment.
interface ob_arbiter_if #(
  parameter int DATA_W = 8,
  parameter int N_REQ  = 4,
  parameter int SLOTS  = 5
);
  localparam int CNT_W = $clog2(SLOTS + 1);

  logic [N_REQ-1:0]        req;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic [N_REQ-1:0]        gnt;
  logic                    ob_en;
  logic [DATA_W-1:0]       ob_data;
  logic                    ob_stored;
  logic                    slot_free;
  logic [CNT_W-1:0]        count;
  logic                    full;
  logic                    err;

  modport master (
    input  req, req_data, ob_stored, slot_free,
    output gnt, ob_en, ob_data, count, full, err
  );

  modport slave (
    output req, req_data, ob_stored, slot_free,
    input  gnt, ob_en, ob_data, count, full, err
  );
endinterface

// File: rtl/rr_picker.sv
// Combinational round-robin pick: first set req bit at or after ptr, wrapping.
module rr_picker #(
  parameter int N_REQ = 4,
  parameter int PTR_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_REQ-1:0] pick,
  output logic             valid
);
  logic [PTR_W-1:0] idx;

  always_comb begin
    pick  = '0;
    valid = 1'b0;
    idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = PTR_W'((int'(ptr) + k) % N_REQ);
      if (!valid && req[idx]) begin
        pick[idx] = 1'b1;
        valid     = 1'b1;
      end
    end
  end
endmodule

// File: rtl/ob_arbiter.sv
// Round-robin arbiter writing one requester word at a time into a SLOTS-deep buffer.
// req sampled -> ob_en next cycle -> ack -> gnt one cycle after ack; stalls while full.
module ob_arbiter
  import ob_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int SLOTS  = 5,
  parameter int N_REQ  = 4
) (
  input logic          clk,
  input logic          rst,
  ob_arbiter_if.master bus
);
  localparam int CNT_W = $clog2(SLOTS + 1);
  localparam int PTR_W = $clog2(N_REQ);

  state_t            state;
  logic [PTR_W-1:0]  ptr;
  logic [PTR_W-1:0]  winner;
  logic [DATA_W-1:0] word;
  logic [TMR_W-1:0]  tmr;
  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  count_nxt;
  logic              full_q;
  logic              err_q;
  logic [N_REQ-1:0]  gnt_q;

  logic [N_REQ-1:0]  pick;
  logic              pick_vld;
  logic [PTR_W-1:0]  pick_idx;
  logic [DATA_W-1:0] pick_word;
  logic [PTR_W-1:0]  next_ptr;
  logic              stored;
  logic              expired;
  logic              underflow;

  rr_picker #(.N_REQ(N_REQ), .PTR_W(PTR_W)) u_picker (
    .req   (bus.req),
    .ptr   (ptr),
    .pick  (pick),
    .valid (pick_vld)
  );

  always_comb begin
    pick_idx  = '0;
    pick_word = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick[i]) begin
        pick_idx  = PTR_W'(i);
        pick_word = bus.req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign next_ptr  = (winner == PTR_W'(N_REQ - 1)) ? '0 : winner + PTR_W'(1);
  assign stored    = (state == ST_WAIT) && bus.ob_stored;
  assign expired   = (state == ST_WAIT) && !bus.ob_stored && (tmr == TMR_W'(TIMEOUT - 1));
  // an ack landing with the release nets to zero, so it is not an underflow
  assign underflow = bus.slot_free && (count_q == '0) && !stored;

  always_comb begin
    count_nxt = count_q;
    if (stored && !bus.slot_free)
      count_nxt = count_q + CNT_W'(1);
    else if (!stored && bus.slot_free && (count_q != '0))
      count_nxt = count_q - CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= ST_IDLE;
      ptr    <= '0;
      winner <= '0;
      word   <= '0;
      tmr    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_vld && !full_q) begin
            winner <= pick_idx;
            word   <= pick_word;
            state  <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          tmr   <= '0;
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (bus.ob_stored) begin
            ptr   <= next_ptr;
            state <= ST_IDLE;
          end else if (tmr == TMR_W'(TIMEOUT - 1)) begin
            state <= ST_IDLE;
          end else begin
            tmr <= tmr + TMR_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // full tracks the registered count, so a release only unblocks IDLE one cycle later
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
      full_q  <= 1'b0;
      err_q   <= 1'b0;
      gnt_q   <= '0;
    end else begin
      count_q <= count_nxt;
      full_q  <= (count_nxt == CNT_W'(SLOTS));
      err_q   <= expired || underflow;
      gnt_q   <= stored ? (N_REQ'(1) << winner) : '0;
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.ob_en   = (state == ST_WRITE);
  assign bus.ob_data = word;
  assign bus.count   = count_q;
  assign bus.full    = full_q;
  assign bus.err     = err_q;
endmodule

// File: tb/tb_ob_arbiter.sv
// Randomized bench for ob_arbiter: a transaction-timing model feeds scoreboard queues
// that a negedge monitor drains, followed by directed single-write and reset-abort cases.
module tb_ob_arbiter;
  localparam int DW = 8;
  localparam int NR = 4;
  localparam int SL = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ob_arbiter_if #(.DATA_W(DW), .N_REQ(NR), .SLOTS(SL)) bus ();

  ob_arbiter #(.DATA_W(DW), .SLOTS(SL), .N_REQ(NR)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct { int cyc; logic [DW-1:0] data; } oben_t;
  typedef struct { int cyc; logic [NR-1:0] g;    } gnt_t;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  bit go       = 1'b0;
  bit mon_on   = 1'b0;

  // model state: who is asking, with what, and when the arbiter is next free
  logic [NR-1:0] pend;
  logic [DW-1:0] dat [NR];
  int  m_ptr, m_cnt, idle_from, ack_cyc, gnt_cyc, gnt_who;
  bit  exp_err [0:4095];
  int    q_cnt  [$];
  oben_t q_oben [$];
  gnt_t  q_gnt  [$];

  initial forever @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_gnt"},     32'(bus.gnt),     32'd0);
    chk({tag, "_ob_en"},   32'(bus.ob_en),   32'd0);
    chk({tag, "_ob_data"}, 32'(bus.ob_data), 32'd0);
    chk({tag, "_count"},   32'(bus.count),   32'd0);
    chk({tag, "_full"},    32'(bus.full),    32'd0);
    chk({tag, "_err"},     32'(bus.err),     32'd0);
  endtask

  task automatic drive_cycle(input int c);
    int p, w, d, r;
    bit inc, sf;
    if (c == gnt_cyc) pend[gnt_who] = 1'b0;
    p = (c < 120) ? 100 : (c < 1200) ? 25 : 0;
    for (int i = 0; i < NR; i++) begin
      if (!pend[i] && ($urandom_range(0, 99) < p)) begin
        pend[i] = 1'b1;
        dat[i]  = DW'($urandom);
      end
    end
    if (c < 120)       sf = (c >= 60) && ($urandom_range(0, 5) == 0);
    else if (c < 1200) sf = ($urandom_range(0, 3) == 0);
    else               sf = ($urandom_range(0, 1) == 0);
    inc = (c == ack_cyc);

    bus.req = pend;
    for (int i = 0; i < NR; i++) bus.req_data[i*DW +: DW] = dat[i];
    bus.slot_free = sf;
    bus.ob_stored = inc;

    if ((c >= idle_from) && (pend != '0) && (m_cnt != SL)) begin
      w = -1;
      for (int k = 0; k < NR; k++)
        if (w < 0 && pend[(m_ptr + k) % NR]) w = (m_ptr + k) % NR;
      q_oben.push_back('{c + 1, dat[w]});
      if (c < 120) d = 0;
      else begin
        r = $urandom_range(0, 7);
        d = (r < 4) ? 0 : r - 3;
      end
      if (d < 4) begin
        ack_cyc   = c + 2 + d;
        gnt_cyc   = c + 3 + d;
        gnt_who   = w;
        q_gnt.push_back('{gnt_cyc, NR'(1) << w});
        idle_from = gnt_cyc;
        m_ptr     = (w + 1) % NR;
      end else begin
        exp_err[c + 6] = 1'b1;
        idle_from      = c + 6;
      end
    end

    if (inc && !sf) m_cnt++;
    else if (sf && !inc) begin
      if (m_cnt > 0) m_cnt--;
      else exp_err[c + 1] = 1'b1;
    end
    q_cnt.push_back(m_cnt);
  endtask

  task automatic mon_cycle();
    oben_t eo;
    gnt_t  eg;
    int    ec;
    int    c;
    c = cyc;
    if (bus.ob_en) begin
      chk("oben_gnt_excl", 32'(bus.gnt), 32'd0);
      if (q_oben.size() == 0) chk("ob_en_unexpected", 32'(bus.ob_en), 32'd0);
      else begin
        eo = q_oben.pop_front();
        chk("ob_en_cycle", 32'(c), 32'(eo.cyc));
        chk("ob_data", 32'(bus.ob_data), 32'(eo.data));
      end
    end
    if (bus.gnt != '0) begin
      chk("gnt_onehot", 32'($countones(bus.gnt)), 32'd1);
      if (q_gnt.size() == 0) chk("gnt_unexpected", 32'(bus.gnt), 32'd0);
      else begin
        eg = q_gnt.pop_front();
        chk("gnt_cycle", 32'(c), 32'(eg.cyc));
        chk("gnt_value", 32'(bus.gnt), 32'(eg.g));
      end
    end
    chk("err", 32'(bus.err), 32'(exp_err[c]));
    if (q_cnt.size() > 0) begin
      ec = q_cnt.pop_front();
      chk("count", 32'(bus.count), 32'(ec));
      chk("full", 32'(bus.full), 32'(ec == SL));
    end
  endtask

  initial begin
    wait (go);
    forever begin
      @(negedge clk);
      if (mon_on) mon_cycle();
    end
  end

  initial begin
    rst           = 1'b0;
    bus.req       = '0;
    bus.req_data  = '0;
    bus.ob_stored = 1'b0;
    bus.slot_free = 1'b0;
    pend = '0;
    for (int i = 0; i < NR; i++) dat[i] = '0;
    m_ptr = 0; m_cnt = 0; idle_from = 0; ack_cyc = -1; gnt_cyc = -1; gnt_who = 0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");

    rst    = 1'b1;
    cyc    = 0;
    go     = 1'b1;
    mon_on = 1'b1;
    #1 drive_cycle(cyc);
    while ((cyc < 1300 || pend != '0 || cyc < idle_from + 3) && cyc < 3000) begin
      @(negedge clk);
      #1 drive_cycle(cyc);
    end
    if (cyc >= 3000) chk("drain_pending", 32'(pend), 32'd0);
    @(posedge clk);
    #2 mon_on = 1'b0;
    chk("ob_en_leftover", 32'(q_oben.size()), 32'd0);
    chk("gnt_leftover", 32'(q_gnt.size()), 32'd0);

    // directed: single write of 0xA5 from requester 0
    @(negedge clk);
    rst = 1'b0; bus.req = '0; bus.slot_free = 1'b0; bus.ob_stored = 1'b0;
    #1 chk_all_zero("mid_reset");
    @(negedge clk); rst = 1'b1;
    @(negedge clk); bus.req = 4'b0001; bus.req_data = 32'h0000_00A5;
    @(negedge clk);
    chk("single_ob_en", 32'(bus.ob_en), 32'd1);
    chk("single_ob_data", 32'(bus.ob_data), 32'hA5);
    chk("single_gnt_early", 32'(bus.gnt), 32'd0);
    @(negedge clk);
    chk("single_ob_en_once", 32'(bus.ob_en), 32'd0);
    bus.ob_stored = 1'b1;
    @(negedge clk);
    bus.ob_stored = 1'b0;
    chk("single_gnt", 32'(bus.gnt), 32'b0001);
    chk("single_count", 32'(bus.count), 32'd1);
    chk("single_err", 32'(bus.err), 32'd0);
    bus.req = '0;
    @(negedge clk);
    chk("single_gnt_pulse", 32'(bus.gnt), 32'd0);

    // directed: reset asserted while waiting for the ack aborts the write
    bus.req = 4'b0010; bus.req_data = 32'h0000_3C00;
    @(negedge clk);
    chk("abort_ob_en", 32'(bus.ob_en), 32'd1);
    chk("abort_ob_data", 32'(bus.ob_data), 32'h3C);
    @(negedge clk);
    rst = 1'b0; bus.ob_stored = 1'b1;
    #1 chk_all_zero("wait_reset");
    @(negedge clk);
    rst = 1'b1; bus.ob_stored = 1'b0; bus.req = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort_no_gnt", 32'(bus.gnt), 32'd0);
      chk("abort_no_ob_en", 32'(bus.ob_en), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
